// File: rtl/serial_cmd_rx.sv
// Serial command/data receiver: assembles MSB-first bits into words, decodes commands, captures payloads.
// Optional trailing even-parity bit per frame when the PARITY_EN macro is defined.
module serial_cmd_rx #(
   parameter int WORD_W        = 8,
   parameter int PAYLOAD_WORDS = 1,
   parameter int PCNT_W        = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bit_in,
   input  logic                         bit_valid,
   input  logic                         sync,
   input  logic                         ready_in,
   output logic                         ready_out,
   output logic [$clog2(WORD_W+1)-1:0]  bit_cnt,
   output logic [WORD_W-1:0]            cmd_out,
   output logic                         cmd_valid,
   output logic                         unknown_cmd,
   output logic [WORD_W-1:0]            data_out,
   output logic                         data_valid,
   output logic [PCNT_W-1:0]            payload_left,
   output logic [1:0]                   scanner_sel,
   output logic                         parity_err
);

   localparam int CNT_W = $clog2(WORD_W+1);

   // With parity the shifter holds the whole word and the parity bit arrives as the frame's last bit.
`ifdef PARITY_EN
   localparam int SHIFT_W = WORD_W;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W);
`else
   localparam int SHIFT_W = WORD_W - 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
`endif

   localparam logic [0:0] ST_CMD  = 1'b0;
   localparam logic [0:0] ST_DATA = 1'b1;

   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [0:0]         state_q, state_d;
   logic [WORD_W-1:0]  cmd_q, cmd_d;
   logic [WORD_W-1:0]  data_q, data_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic               unknown_q, unknown_d;
   logic               data_valid_q, data_valid_d;
   logic [PCNT_W-1:0]  payload_q, payload_d;
   logic [1:0]         sel_q, sel_d;
   logic [WORD_W-1:0]  word;
   logic               wordOk;
   logic               frameDone;

`ifdef PARITY_EN
   logic parity_err_q, parity_err_d;
   assign word   = shift_q;
   assign wordOk = ((^shift_q) == bit_in);
`else
   assign word   = {shift_q, bit_in};
   assign wordOk = 1'b1;
`endif

   // Next-state logic: sync wins over any bit arriving in the same cycle.
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      state_d      = state_q;
      cmd_d        = cmd_q;
      data_d       = data_q;
      cmd_valid_d  = 1'b0;
      unknown_d    = 1'b0;
      data_valid_d = 1'b0;
      payload_d    = payload_q;
      sel_d        = sel_q;
      frameDone    = 1'b0;
`ifdef PARITY_EN
      parity_err_d = 1'b0;
`endif
      if (sync) begin
         bit_cnt_d = '0;
         shift_d   = '0;
         state_d   = ST_CMD;
         payload_d = '0;
      end else if (bit_valid) begin
         shift_d = {shift_q[SHIFT_W-2:0], bit_in};
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            frameDone = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end

`ifdef PARITY_EN
      if (frameDone && !wordOk) begin
         parity_err_d = 1'b1;
      end
`endif

      if (frameDone && wordOk) begin
         if (state_q == ST_CMD) begin
            cmd_d       = word;
            cmd_valid_d = 1'b1;
            case (word)
               WORD_W'(1): sel_d = 2'b10;
               WORD_W'(3): sel_d = 2'b01;
               WORD_W'(5): data_d = '0;
               WORD_W'(7): begin
                  payload_d = PCNT_W'(PAYLOAD_WORDS);
                  state_d   = ST_DATA;
               end
               WORD_W'(2), WORD_W'(4), WORD_W'(6), WORD_W'(8): ;
               default: unknown_d = 1'b1;
            endcase
         end else begin
            data_d       = word;
            data_valid_d = 1'b1;
            payload_d    = payload_q - PCNT_W'(1);
            if (payload_q == PCNT_W'(1)) begin
               state_d = ST_CMD;
            end
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         state_q      <= ST_CMD;
         cmd_q        <= '0;
         data_q       <= '0;
         cmd_valid_q  <= 1'b0;
         unknown_q    <= 1'b0;
         data_valid_q <= 1'b0;
         payload_q    <= '0;
         sel_q        <= 2'b00;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         data_q       <= data_d;
         cmd_valid_q  <= cmd_valid_d;
         unknown_q    <= unknown_d;
         data_valid_q <= data_valid_d;
         payload_q    <= payload_d;
         sel_q        <= sel_d;
      end
   end

`ifdef PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign ready_out    = ready_in;
   assign bit_cnt      = bit_cnt_q;
   assign cmd_out      = cmd_q;
   assign cmd_valid    = cmd_valid_q;
   assign unknown_cmd  = unknown_q;
   assign data_out     = data_q;
   assign data_valid   = data_valid_q;
   assign payload_left = payload_q;
   assign scanner_sel  = sel_q;

endmodule
